// File: rtl/resp_checker_pkg.sv
// -----------------------------------------------------------------------------
// resp_checker_pkg
//   Shared types and constants for the response checker slice.
//
//   Contents:
//     state_t    - checker FSM states (IDLE / RUN / DONE)
//     NUM_VEC    - number of stimulus vectors in one sweep (64)
//     OP_W       - operand / response width (3)
//     IDX_W      - vector index width (6)
//     CNT_W      - error counter width (7, holds 0..64)
//     MISR_POLY  - Galois feedback polynomial of the signature register
//     MISR_SEED  - value loaded into the signature register at sweep start
//     misr_next  - one MISR step: Galois shift, then fold in the response
// -----------------------------------------------------------------------------
package resp_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int NUM_VEC = 64;
    localparam int OP_W    = 3;
    localparam int IDX_W   = 6;
    localparam int CNT_W   = 7;

    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;

    // Shift left; when the bit falling out of [15] is set, fold the
    // polynomial back in. The response is then XORed into the low bits.
    function automatic logic [15:0] misr_next(input logic [15:0] cur,
                                              input logic [OP_W-1:0] din);
        logic [15:0] shifted;
        shifted = {cur[14:0], 1'b0} ^ (cur[15] ? MISR_POLY : 16'h0000);
        return shifted ^ {13'b0, din};
    endfunction

endpackage

// File: rtl/resp_misr.sv
// -----------------------------------------------------------------------------
// resp_misr
//   16-bit multiple-input signature register compacting the DUT responses
//   of one sweep into a single signature.
//
//   Ports:
//     clk        in   clock, rising edge
//     rst        in   synchronous active-high reset, clears the signature
//     seed_load  in   load MISR_SEED (takes priority over shift_en)
//     shift_en   in   perform one MISR step with din
//     din[2:0]   in   response word folded into the signature
//     sig[15:0]  out  current signature
// -----------------------------------------------------------------------------
module resp_misr
    import resp_checker_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            seed_load,
    input  logic            shift_en,
    input  logic [OP_W-1:0] din,
    output logic [15:0]     sig
);

    always_ff @(posedge clk) begin
        if (rst) begin
            sig <= 16'h0000;
        end else if (seed_load) begin
            sig <= MISR_SEED;
        end else if (shift_en) begin
            sig <= misr_next(sig, din);
        end
    end

endmodule

// File: rtl/resp_checker.sv
// -----------------------------------------------------------------------------
// resp_checker
//   Exhaustive response checker for a 3-bit x 3-bit two-operand DUT. A sweep
//   drives all 64 (a, b) combinations, a outer and b inner, one per cycle,
//   and compares the DUT response against a golden response. It reports the
//   number of mismatches, the index of the first mismatch and a pass flag.
//
//   Build option:
//     RESP_CHECKER_MISR_EN  defined   -> responses are also compacted into a
//                                        16-bit MISR signature on sig
//                           undefined -> no MISR, sig tied to 16'h0000
//
//   Ports:
//     clk                 in   clock, rising edge
//     rst                 in   synchronous active-high reset
//     start               in   level-sampled; starts a sweep in IDLE or DONE
//     a[2:0], b[2:0]      out  registered stimulus operands
//     y_in[2:0]           in   DUT response to current a/b
//     exp_in[2:0]         in   golden response to current a/b
//     busy                out  high while sweeping (RUN)
//     done                out  high when results are valid (DONE)
//     pass                out  high in DONE when no mismatch was seen
//     err_cnt[6:0]        out  mismatch count, saturates at 64
//     first_fail_idx[5:0] out  vector index of the first mismatch
//     first_fail_vld      out  first_fail_idx holds a captured index
//     sig[15:0]           out  MISR signature (see build option)
// -----------------------------------------------------------------------------
module resp_checker
    import resp_checker_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [OP_W-1:0]  a,
    output logic [OP_W-1:0]  b,
    input  logic [OP_W-1:0]  y_in,
    input  logic [OP_W-1:0]  exp_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [IDX_W-1:0] first_fail_idx,
    output logic             first_fail_vld,
    output logic [15:0]      sig
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);
    localparam logic [CNT_W-1:0] ERR_MAX  = CNT_W'(NUM_VEC);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_inc;
    logic             mismatch;
    logic [CNT_W-1:0] err_cnt_next;

    // Case-inequality so that X/Z on the response counts as a failure
    // instead of silently comparing equal.
    // NOTE: every signal written in an always_comb gets a default value
    // first, so no path through the block can leave it unassigned and
    // infer a latch.
    always_comb begin
        mismatch     = (y_in !== exp_in);
        err_cnt_next = err_cnt;
        if (mismatch && (err_cnt != ERR_MAX)) begin
            err_cnt_next = err_cnt + 1'b1;
        end
    end

    assign idx_inc = idx + 1'b1;

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours, matching the
    // hardware regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            idx            <= '0;
            a              <= '0;
            b              <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_cnt        <= '0;
            first_fail_idx <= '0;
            first_fail_vld <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    // Results in DONE are held until a new start arrives.
                    if (start) begin
                        state          <= ST_RUN;
                        idx            <= '0;
                        a              <= '0;
                        b              <= '0;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        err_cnt        <= '0;
                        first_fail_idx <= '0;
                        first_fail_vld <= 1'b0;
                    end
                end

                ST_RUN: begin
                    // Compare the vector currently on a/b, then advance.
                    err_cnt <= err_cnt_next;
                    if (mismatch && !first_fail_vld) begin
                        first_fail_idx <= idx;
                        first_fail_vld <= 1'b1;
                    end
                    if (idx == LAST_IDX) begin
                        // a/b stay on the last vector (3'b111, 3'b111).
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_cnt_next == '0);
                    end else begin
                        idx    <= idx_inc;
                        {a, b} <= idx_inc;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    pass  <= 1'b0;
                end
            endcase
        end
    end

`ifdef RESP_CHECKER_MISR_EN
    logic seed_load;
    logic shift_en;

    // Seed on the same edge that launches a sweep, then shift once per
    // compared vector so the signature covers exactly the 64 responses.
    assign seed_load = start && (state != ST_RUN);
    assign shift_en  = (state == ST_RUN);

    resp_misr u_misr (
        .clk       (clk),
        .rst       (rst),
        .seed_load (seed_load),
        .shift_en  (shift_en),
        .din       (y_in),
        .sig       (sig)
    );
`else
    assign sig = 16'h0000;
`endif

endmodule

// File: tb/tb_resp_checker.sv
// -----------------------------------------------------------------------------
// tb_resp_checker
//   Self-checking bench for resp_checker. The DUT model is a ^ b; a table of
//   response-fault modes drives complete sweeps, each with hand-computed
//   expected results, followed by directed reset-mid-run and DONE-hold
//   sequences. Signature checks depend on RESP_CHECKER_MISR_EN.
// -----------------------------------------------------------------------------
module tb_resp_checker;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  a;
    logic [2:0]  b;
    logic [2:0]  y_in;
    logic [2:0]  exp_in;
    logic        busy;
    logic        done;
    logic        pass;
    logic [6:0]  err_cnt;
    logic [5:0]  first_fail_idx;
    logic        first_fail_vld;
    logic [15:0] sig;

    int n_cmp  = 0;
    int n_fail = 0;
    int mode   = 0;

    resp_checker dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .a              (a),
        .b              (b),
        .y_in           (y_in),
        .exp_in         (exp_in),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_cnt        (err_cnt),
        .first_fail_idx (first_fail_idx),
        .first_fail_vld (first_fail_vld),
        .sig            (sig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Response generator: 0 golden, 1 stuck-at-0 on bit 0, 2 fault at idx 37,
    // 3 X response at idx 5, 4 golden model inverted (every vector fails).
    always_comb begin
        logic [2:0] g;
        g      = a ^ b;
        y_in   = g;
        exp_in = g;
        case (mode)
            1: y_in = g & 3'b110;
            2: if ({a, b} == 6'd37) y_in = ~g;
            3: if ({a, b} == 6'd5) y_in = 3'bxxx;
            4: exp_in = ~g;
            default: ;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Launch a sweep and follow it to DONE. Cycle 1 is the cycle after the
    // edge that samples start; done_at is the first cycle with done high.
    task automatic run_sweep(input bit hold, output int busy_n,
                             output int done_at, output int bad_pass);
        busy_n   = 0;
        done_at  = 0;
        bad_pass = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (busy) busy_n++;
            if (!done && pass) bad_pass++;
            if (done) begin
                done_at = c;
                break;
            end
            @(posedge clk);
        end
        start = 1'b0;
    endtask

    typedef struct {
        string      name;
        int         mode;
        bit         hold;
        logic [6:0] exp_err;
        logic [5:0] exp_ffi;
        logic       exp_vld;
        logic       exp_pass;
    } vec_t;

    vec_t        vecs[7];
    logic [15:0] sigs[7];

    initial begin
        int busy_n, done_at, bad_pass;
        int waited;

        vecs[0] = '{"golden",      0, 1'b0, 7'd0,  6'd0,  1'b0, 1'b1};
        vecs[1] = '{"stuck_at",    1, 1'b0, 7'd32, 6'd1,  1'b1, 1'b0};
        vecs[2] = '{"golden_hold", 0, 1'b1, 7'd0,  6'd0,  1'b0, 1'b1};
        vecs[3] = '{"fault37",     2, 1'b0, 7'd1,  6'd37, 1'b1, 1'b0};
        vecs[4] = '{"x_at5",       3, 1'b0, 7'd1,  6'd5,  1'b1, 1'b0};
        vecs[5] = '{"all_wrong",   4, 1'b0, 7'd64, 6'd0,  1'b1, 1'b0};
        vecs[6] = '{"golden_re",   0, 1'b0, 7'd0,  6'd0,  1'b0, 1'b1};

        // Reset state
        rst   = 1'b1;
        start = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_a",    32'(a), 32'd0);
        check("rst_b",    32'(b), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_err",  32'(err_cnt), 32'd0);
        check("rst_ffi",  32'(first_fail_idx), 32'd0);
        check("rst_vld",  32'(first_fail_vld), 32'd0);
        check("rst_sig",  32'(sig), 32'd0);
        start = 1'b0;
        rst   = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // Table-driven sweeps
        for (int i = 0; i < 7; i++) begin
            mode = vecs[i].mode;
            run_sweep(vecs[i].hold, busy_n, done_at, bad_pass);
            check({vecs[i].name, "_busy_cycles"}, 32'(busy_n), 32'd64);
            check({vecs[i].name, "_done_cycle"},  32'(done_at), 32'd65);
            check({vecs[i].name, "_pass_early"},  32'(bad_pass), 32'd0);
            check({vecs[i].name, "_err_cnt"},     32'(err_cnt), 32'(vecs[i].exp_err));
            check({vecs[i].name, "_ffi"},         32'(first_fail_idx), 32'(vecs[i].exp_ffi));
            check({vecs[i].name, "_vld"},         32'(first_fail_vld), 32'(vecs[i].exp_vld));
            check({vecs[i].name, "_pass"},        32'(pass), 32'(vecs[i].exp_pass));
            check({vecs[i].name, "_ab_hold"},     32'({a, b}), 32'h3f);
            sigs[i] = sig;
`ifndef RESP_CHECKER_MISR_EN
            check({vecs[i].name, "_sig_zero"}, 32'(sig), 32'd0);
`endif
            // Results stay put in DONE while start is low.
            repeat (4) @(negedge clk);
            check({vecs[i].name, "_done_hold"}, 32'({done, busy, err_cnt}),
                  32'({1'b1, 1'b0, vecs[i].exp_err}));
        end

`ifdef RESP_CHECKER_MISR_EN
        check("sig_nonzero",       32'(sigs[0] != 16'h0000), 32'd1);
        check("sig_repeat",        32'(sigs[6]), 32'(sigs[0]));
        check("sig_repeat_hold",   32'(sigs[2]), 32'(sigs[0]));
        check("sig_fault_differs", 32'(sigs[3] != sigs[0]), 32'd1);
`endif

        // Reset mid-run at idx 20 with a failing response pattern
        mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        waited = 0;
        while (({a, b} != 6'd20) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("midrun_reach_idx20", 32'({a, b}), 32'd20);
        check("midrun_err_before",  32'(err_cnt), 32'd10);
        rst = 1'b1;
        @(negedge clk);
        check("midrun_busy", 32'(busy), 32'd0);
        check("midrun_done", 32'(done), 32'd0);
        check("midrun_ab",   32'({a, b}), 32'd0);
        check("midrun_err",  32'(err_cnt), 32'd0);
        check("midrun_vld",  32'(first_fail_vld), 32'd0);
        check("midrun_sig",  32'(sig), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("midrun_idle", 32'({busy, done}), 32'd0);

        mode = 0;
        run_sweep(1'b0, busy_n, done_at, bad_pass);
        check("after_rst_busy_cycles", 32'(busy_n), 32'd64);
        check("after_rst_done_cycle",  32'(done_at), 32'd65);
        check("after_rst_err",         32'(err_cnt), 32'd0);
        check("after_rst_pass",        32'(pass), 32'd1);
`ifdef RESP_CHECKER_MISR_EN
        check("after_rst_sig", 32'(sig), 32'(sigs[0]));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
